// File: rtl/multi_cycle_ctr_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
// Carries the opcode/memory-ready inputs and every per-state datapath control.
interface multi_cycle_ctr_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned ST_W    = 3
) ();
    logic [OP_W-1:0]    op;
    logic               mem_ready;
    logic               PCWr;
    logic               PCWrCond;
    logic [1:0]         PCSrc;
    logic               IorD;
    logic               MemRd;
    logic               MemWr;
    logic               IRWr;
    logic               RegWr;
    logic               RegDst;
    logic               MemtoReg;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               Extop;
    logic [ALUOP_W-1:0] ALUop;
    logic               instr_done;
    logic               illegal_op;
    logic               mem_err;
    logic [ST_W-1:0]    state_o;

    modport master (
        input  op, mem_ready,
        output PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, Extop, ALUop, instr_done, illegal_op, mem_err, state_o
    );

    modport slave (
        output op, mem_ready,
        input  PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, Extop, ALUop, instr_done, illegal_op, mem_err, state_o
    );
endinterface

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle main controller: sequences IF/ID/EX/MEM/WB per opcode with variable-latency
// memory, optional access timeout and an illegal-opcode trap.
module multi_cycle_ctr #(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned ST_W        = 3
) (
    input logic              clk,
    input logic              rst_n,
    multi_cycle_ctr_if.master bus
);
    typedef enum logic [2:0] {
        StIdle = 3'd0, StIf = 3'd1, StId = 3'd2, StEx = 3'd3, StMem = 3'd4, StWb = 3'd5
    } state_e;

    localparam logic [OP_W-1:0] OpR    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpAddi = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OpAndi = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OpOri  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OpXori = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OpBeq  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OpLui  = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OpJ    = OP_W'(6'b000010);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_r, is_lw, is_sw, is_beq, is_j, is_legal;
    logic [3:0]        op_alu, alu;
    logic              op_ext;
    logic              stalled, timeout;

    always_comb begin
        op_alu   = 4'b0000;
        op_ext   = 1'b0;
        is_legal = 1'b1;
        case (bus.op)
            OpR:    op_alu = 4'b1111;
            OpAddi: begin op_alu = 4'b1110; op_ext = 1'b1; end
            OpAndi: op_alu = 4'b0010;
            OpOri:  op_alu = 4'b0011;
            OpXori: op_alu = 4'b0111;
            OpLw:   begin op_alu = 4'b0001; op_ext = 1'b1; end
            OpSw:   begin op_alu = 4'b0001; op_ext = 1'b1; end
            OpBeq:  begin op_alu = 4'b0101; op_ext = 1'b1; end
            OpLui:  op_alu = 4'b0110;
            OpJ:    op_alu = 4'b0000;
            default: is_legal = 1'b0;
        endcase
    end

    assign is_r   = (bus.op == OpR);
    assign is_lw  = (bus.op == OpLw);
    assign is_sw  = (bus.op == OpSw);
    assign is_beq = (bus.op == OpBeq);
    assign is_j   = (bus.op == OpJ);

    assign stalled = ((state_q == StIf) || (state_q == StMem)) && !bus.mem_ready;
    // mem_ready outranks the timeout because stalled already excludes it
    assign timeout = (MEM_TIMEOUT != 0) && stalled && (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        alu            = 4'b0000;
        bus.PCWr       = 1'b0;
        bus.PCWrCond   = 1'b0;
        bus.PCSrc      = 2'b00;
        bus.IorD       = 1'b0;
        bus.MemRd      = 1'b0;
        bus.MemWr      = 1'b0;
        bus.IRWr       = 1'b0;
        bus.RegWr      = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.Extop      = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        bus.mem_err    = 1'b0;
        case (state_q)
            StIdle: state_d = StIf;
            StIf: begin
                bus.MemRd   = !timeout;
                bus.ALUSrcB = 2'b01;
                alu         = 4'b0001;
                bus.IRWr    = bus.mem_ready;
                bus.PCWr    = bus.mem_ready;
                bus.mem_err = timeout;
                if (bus.mem_ready) state_d = StId;
            end
            StId: begin
                bus.ALUSrcB = 2'b11;
                alu         = 4'b0001;
                bus.Extop   = op_ext;
                if (is_j) begin
                    bus.PCWr       = 1'b1;
                    bus.PCSrc      = 2'b10;
                    bus.instr_done = 1'b1;
                    state_d        = StIf;
                end else if (!is_legal) begin
                    bus.illegal_op = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = StIf;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                bus.ALUSrcA = 1'b1;
                bus.Extop   = op_ext;
                alu         = op_alu;
                if (is_r) begin
                    state_d = StWb;
                end else if (is_beq) begin
                    bus.PCWrCond   = 1'b1;
                    bus.PCSrc      = 2'b01;
                    bus.instr_done = 1'b1;
                    state_d        = StIf;
                end else begin
                    bus.ALUSrcB = 2'b10;
                    state_d     = (is_lw || is_sw) ? StMem : StWb;
                end
            end
            StMem: begin
                bus.IorD    = 1'b1;
                bus.Extop   = op_ext;
                alu         = op_alu;
                bus.MemRd   = is_lw && !timeout;
                bus.MemWr   = is_sw && !timeout;
                bus.mem_err = timeout;
                if (bus.mem_ready) begin
                    bus.instr_done = !is_lw;
                    state_d        = is_lw ? StWb : StIf;
                end else if (timeout) begin
                    state_d = StIf;
                end
            end
            StWb: begin
                bus.RegWr      = 1'b1;
                bus.RegDst     = is_r;
                bus.MemtoReg   = is_lw;
                bus.Extop      = op_ext;
                alu            = op_alu;
                bus.instr_done = 1'b1;
                state_d        = StIf;
            end
            default: state_d = StIdle;
        endcase
        bus.ALUop = ALUOP_W'(alu);
    end

    // Aborts re-enter IF from IF, so the timeout itself must also clear the count
    always_comb begin
        cnt_d = cnt_q;
        if (bus.mem_ready || timeout || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (stalled && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state_o = ST_W'(state_q);
endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Randomized scoreboard bench for multi_cycle_ctr: a phase-list reference model queues the
// expected control word for every cycle and a negedge monitor compares it with the DUT.
module tb_multi_cycle_ctr;
    localparam int unsigned OP_W        = 6;
    localparam int unsigned ALUOP_W     = 4;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned ST_W        = 3;

    localparam logic [5:0] OpR = 6'b000000, OpAddi = 6'b001000, OpAndi = 6'b001100;
    localparam logic [5:0] OpOri = 6'b001101, OpXori = 6'b001110, OpLw = 6'b100011;
    localparam logic [5:0] OpSw = 6'b101011, OpBeq = 6'b000100, OpLui = 6'b001111;
    localparam logic [5:0] OpJ = 6'b000010, OpBad = 6'b111111;

    localparam int KR = 0, KI = 1, KLw = 2, KSw = 3, KBeq = 4, KJ = 5, KBad = 6;

    typedef logic [24:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctr_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .ST_W(ST_W)) bus ();

    multi_cycle_ctr #(
        .OP_W(OP_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .ST_W(ST_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    vec_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [5:0] legal_ops [10] = '{OpR, OpAddi, OpAndi, OpOri, OpXori, OpLw, OpSw, OpBeq,
                                   OpLui, OpJ};

    function automatic int kind_of(logic [5:0] op);
        case (op)
            OpR:                                 return KR;
            OpAddi, OpAndi, OpOri, OpXori, OpLui: return KI;
            OpLw:                                return KLw;
            OpSw:                                return KSw;
            OpBeq:                               return KBeq;
            OpJ:                                 return KJ;
            default:                             return KBad;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic [5:0] op);
        case (op)
            OpR:       return 4'b1111;
            OpAddi:    return 4'b1110;
            OpAndi:    return 4'b0010;
            OpOri:     return 4'b0011;
            OpXori:    return 4'b0111;
            OpLw, OpSw: return 4'b0001;
            OpBeq:     return 4'b0101;
            OpLui:     return 4'b0110;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic ext_of(logic [5:0] op);
        return (op == OpAddi) || (op == OpLw) || (op == OpSw) || (op == OpBeq);
    endfunction

    function automatic vec_t pack_obs();
        return {bus.PCWr, bus.PCWrCond, bus.PCSrc, bus.IorD, bus.MemRd, bus.MemWr, bus.IRWr,
                bus.RegWr, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.Extop,
                bus.ALUop, bus.instr_done, bus.illegal_op, bus.mem_err, bus.state_o};
    endfunction

    // Phase numbers coincide with the documented state_o encoding
    function automatic vec_t expect_vec(int ph, logic [5:0] op, logic rdy, logic err);
        logic       pcwr = 0, pcwrc = 0, iord = 0, mrd = 0, mwr = 0, irwr = 0, rwr = 0;
        logic       rdst = 0, m2r = 0, sa = 0, ext = 0, done = 0, ill = 0, merr = 0;
        logic [1:0] pcsrc = 0, sb = 0;
        logic [3:0] alu = 0;
        int         k = kind_of(op);
        case (ph)
            1: begin
                mrd = !err; sb = 2'b01; alu = 4'b0001; irwr = rdy; pcwr = rdy; merr = err;
            end
            2: begin
                sb = 2'b11; alu = 4'b0001; ext = ext_of(op);
                if (k == KJ) begin pcwr = 1; pcsrc = 2'b10; done = 1; end
                if (k == KBad) begin ill = 1; done = 1; end
            end
            3: begin
                sa = 1; ext = ext_of(op); alu = alu_of(op);
                if (k == KR) sb = 2'b00;
                else if (k == KBeq) begin sb = 2'b00; pcwrc = 1; pcsrc = 2'b01; done = 1; end
                else sb = 2'b10;
            end
            4: begin
                iord = 1; ext = ext_of(op); alu = alu_of(op);
                mrd = (k == KLw) && !err; mwr = (k == KSw) && !err;
                done = (k == KSw) && rdy; merr = err;
            end
            5: begin
                rwr = 1; rdst = (k == KR); m2r = (k == KLw); done = 1;
                ext = ext_of(op); alu = alu_of(op);
            end
            default: ;
        endcase
        return {pcwr, pcwrc, pcsrc, iord, mrd, mwr, irwr, rwr, rdst, m2r, sa, sb, ext, alu,
                done, ill, merr, 3'(ph)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            vec_t e;
            vec_t a;
            e = exp_q.pop_front();
            a = pack_obs();
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL ctl t=%0t state exp=%0d: got=%h exp=%h", $time, e[2:0], a, e);
            end
        end
    end

    task automatic cyc(int ph, logic rdy, logic err, logic [5:0] op);
        @(posedge clk);
        #1;
        bus.op        = op;
        bus.mem_ready = rdy;
        exp_q.push_back(expect_vec(ph, op, rdy, err));
    endtask

    task automatic check_zero(string name);
        n_vec++;
        if (pack_obs() !== '0) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", name, pack_obs(), 25'h0);
        end
    endtask

    // A stall count at or above the timeout becomes an abort on the last allowed stall
    task automatic mem_phase(int ph, logic [5:0] op, int stalls, output bit ok);
        logic [5:0] opv;
        if (stalls >= int'(MEM_TIMEOUT)) begin
            for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
                opv = (ph == 1) ? 6'($urandom) : op;
                cyc(ph, 1'b0, (i == int'(MEM_TIMEOUT) - 1), opv);
            end
            ok = 1'b0;
        end else begin
            for (int i = 0; i < stalls; i++) begin
                opv = (ph == 1) ? 6'($urandom) : op;
                cyc(ph, 1'b0, 1'b0, opv);
            end
            cyc(ph, 1'b1, 1'b0, op);
            ok = 1'b1;
        end
    endtask

    task automatic run_instr(logic [5:0] op, int if_st, int mem_st);
        bit ok;
        int k = kind_of(op);
        mem_phase(1, op, if_st, ok);
        if (!ok) mem_phase(1, op, 0, ok);
        cyc(2, 1'($urandom), 1'b0, op);
        if (k == KJ || k == KBad) return;
        cyc(3, 1'($urandom), 1'b0, op);
        if (k == KBeq) return;
        if (k == KLw || k == KSw) begin
            mem_phase(4, op, mem_st, ok);
            if (!ok || k == KSw) return;
        end
        cyc(5, 1'($urandom), 1'b0, op);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.mem_ready = 1'($urandom);
        exp_q.push_back(expect_vec(0, bus.op, bus.mem_ready, 1'b0));
    endtask

    function automatic int rand_stall();
        int r = int'($urandom_range(0, 9));
        return (r < 6) ? 0 : r - 5;
    endfunction

    initial begin
        logic [5:0] op;
        bus.op        = '0;
        bus.mem_ready = 1'b1;
        #3;
        check_zero("reset_outputs");
        release_reset();

        run_instr(OpR, 0, 0);
        run_instr(OpLw, 0, 2);
        run_instr(OpBeq, 0, 0);
        run_instr(OpJ, 0, 0);
        run_instr(OpBad, 1, 0);
        run_instr(OpSw, 0, 4);
        run_instr(OpAddi, 5, 0);
        run_instr(OpSw, 3, 3);

        // Asynchronous reset in the middle of a stalled lw access
        cyc(1, 1'b1, 1'b0, OpLw);
        cyc(2, 1'b1, 1'b0, OpLw);
        cyc(3, 1'b1, 1'b0, OpLw);
        cyc(4, 1'b0, 1'b0, OpLw);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_mem");
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        check_zero("reset_held");
        release_reset();
        run_instr(OpAndi, 0, 0);

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 9)] : 6'($urandom);
            run_instr(op, rand_stall(), rand_stall());
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
